cmem_arb_ctrl: RTL
==================

Name: cmem_arb_ctrl

Overview:
Front-end controller for the 20-bit x 256-entry cmem macro, which has active-low WEN/CEN and a negedge SRAM core.
- Shares the single memory port between two requesters:
  - a fill port that writes pre-computed sums through CADDR;
  - a lookup port that reads through A0.
- Clears the array after reset, arbitrates round-robin between the two ports, and generates the two-phase cmem timing.
- Returns read data with fixed latency.

Parameters:
AW, 8, address width (cmem A0/CADDR width)
DW, 20, data width (cmem D/Q width)
DEPTH, 256, number of entries cleared after reset (must be <= 2**AW)
CLEAR_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to SERVE

Ports:
clk  in  1  clock, rising edge; same net as cmem clk
rst  in  1  synchronous, active-high reset
fill_valid  in  1  fill write request
fill_ready  out  1  fill request accepted this cycle when fill_valid && fill_ready
fill_addr  in  AW  fill write address
fill_data  in  DW  fill write data
rd_valid  in  1  lookup read request
rd_ready  out  1  lookup request accepted this cycle when rd_valid && rd_ready
rd_addr  in  AW  lookup address
rsp_valid  out  1  one-cycle pulse: rsp_data holds the read result
rsp_data  out  DW  read data, held until next rsp_valid
init_done  out  1  high once the post-reset clear is complete
mem_A0  out  AW  to cmem A0
mem_CADDR  out  AW  to cmem CADDR
mem_D  out  DW  to cmem D
mem_WEN  out  1  to cmem WEN, active low
mem_CEN  out  1  to cmem CEN, active low
mem_Q  in  DW  from cmem Q0

Behaviour:
- Reset (rst high at posedge):
  - state=CLEAR if CLEAR_EN, else SERVE; clear counter=0; last_grant=RD.
  - Registered outputs reset to: mem_CEN=1, mem_WEN=1, rsp_valid=0, rsp_data=0, init_done=0 (init_done=1 if CLEAR_EN=0).
  - fill_ready=0 and rd_ready=0 while rst is high.
- Two-phase memory op:
  - Issue cycle k: mem_A0/mem_CADDR/mem_D driven combinationally from the granted source; cmem registers them at the posedge ending k.
  - Access cycle k+1: registered mem_CEN=0; mem_WEN=0 for a write, 1 for a read.
  - Address/data for the op issued in k+1 are driven in parallel, so throughput is one op per cycle.
- Idle cycles: mem_CEN=1, mem_WEN=1; mem_A0/mem_CADDR/mem_D hold their last values (no X).
- Read data path:
  - Capture mem_Q into rsp_data at the posedge ending access cycle k+1.
  - rsp_valid=1 in cycle k+2 only.
  - Read latency is 2 cycles from handshake to rsp_valid.
  - There is no response backpressure.
- Write address routing: mem_CADDR=fill_addr and mem_A0=fill_addr, so either cmem address mux leg is correct.
- Read address routing: mem_A0=rd_addr; mem_CADDR keeps its previous value.
- FSM states:
  - CLEAR:
    - Issue writes of 0 to addresses 0..DEPTH-1, one per cycle; fill_ready=rd_ready=0.
    - After the issue of address DEPTH-1, go to SERVE and set init_done=1 in the next cycle.
  - SERVE:
    - Only fill_valid: fill_ready=1.
    - Only rd_valid: rd_ready=1.
    - Both valid: grant the port opposite to last_grant; the other port's ready=0.
    - last_grant updates on every accepted op.
    - Neither valid: both readies=1 (ready does not depend on valid for a lone requester), nothing issued.
- Ordering:
  - Ops complete in issue order.
  - A read issued the cycle after a write to the same address returns the new data; no bypass is needed, because the SRAM sees the write one cycle earlier.
- rst asserted mid-operation:
  - Any pending access and response is dropped; rsp_valid stays 0.
  - mem_CEN=1 from the next cycle.
  - Clear restarts at address 0.
- Clear counter width is AW+1 so the terminal compare at DEPTH-1 has no wrap ambiguity when DEPTH=2**AW.

Test Plan:
1. Clear sequence: CLEAR_EN=1, release rst.
   - Exactly 256 consecutive cycles of mem_CEN=0/mem_WEN=0 with CADDR 0x00..0xFF and D=0.
   - init_done rises the next cycle; readies stay 0 throughout the clear.
2. Write then read: fill 0x12345 @0x10 in cycle t, read @0x10 in cycle t+1.
   - rsp_valid in t+3 with rsp_data=0x12345.
   - A read @0x11 returns 0x00000.
3. Contention: fill_valid and rd_valid both held high for 4 cycles after init.
   - Grants alternate FILL, RD, FILL, RD.
   - Two rsp_valid pulses, each 2 cycles after its read grant.
4. Back-to-back throughput: 8 consecutive writes @0x20..0x27 (data = addr*3), then 8 consecutive reads.
   - 8 rsp_valid pulses on consecutive cycles with data 0x60, 0x63, ..., 0x75.
5. Reset mid-clear at counter=0x40, and mid-read with a response pending.
   - No rsp_valid after rst; clear restarts at CADDR 0x00; init_done=0 until the new clear finishes.
6. CLEAR_EN=0: after rst, init_done=1 on the first cycle.
   - A lone rd_valid @0x05 gets rd_ready=1 immediately and rsp_valid 2 cycles later.

Source files
------------

// File: rtl/cmem_arb_ctrl_if.sv
// Requester-side bundle for cmem_arb_ctrl: fill write port, lookup read port
// and the read response. master = requester side, slave = controller side.
interface cmem_arb_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 20
);
    logic          fill_valid;
    logic          fill_ready;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output fill_valid, fill_addr, fill_data,
        output rd_valid, rd_addr,
        input  fill_ready, rd_ready,
        input  rsp_valid, rsp_data
    );

    modport slave (
        input  fill_valid, fill_addr, fill_data,
        input  rd_valid, rd_addr,
        output fill_ready, rd_ready,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/cmem_arb_ctrl.sv
// Front-end for the cmem macro: post-reset clear, round-robin fill/lookup
// arbitration, two-phase CEN/WEN timing and fixed 2-cycle read return.
// Ports: clk, rst (sync, active high); req (slave modport: fill, lookup and
// response handshakes); init_done; mem_A0/mem_CADDR/mem_D/mem_WEN/mem_CEN
// toward the macro and mem_Q back from it.
module cmem_arb_ctrl #(
    parameter int AW       = 8,
    parameter int DW       = 20,
    parameter int DEPTH    = 256,
    parameter int CLEAR_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    cmem_arb_ctrl_if.slave req,
    output logic          init_done,
    output logic [AW-1:0] mem_A0,
    output logic [AW-1:0] mem_CADDR,
    output logic [DW-1:0] mem_D,
    output logic          mem_WEN,
    output logic          mem_CEN,
    input  logic [DW-1:0] mem_Q
);
    typedef enum logic {CLEAR, SERVE} state_t;

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_t        state;
    logic [AW:0]   cnt;
    logic          last_rd;
    logic          acc_rd;
    logic [AW-1:0] a0_q;
    logic [AW-1:0] caddr_q;
    logic [DW-1:0] d_q;
    logic          serve;
    logic          clr_go;
    logic          fill_go;
    logic          rd_go;
    logic          wr_go;

    // Readies depend only on the competing port's valid and last_grant,
    // so a lone requester sees ready without a combinational loop.
    always_comb begin
        serve          = (state == SERVE) && !rst;
        clr_go         = (state == CLEAR) && !rst;
        req.fill_ready = serve && (!req.rd_valid || last_rd);
        req.rd_ready   = serve && (!req.fill_valid || !last_rd);
        fill_go        = req.fill_valid && req.fill_ready;
        rd_go          = req.rd_valid && req.rd_ready;
        wr_go          = clr_go || fill_go;
        mem_A0         = a0_q;
        mem_CADDR      = caddr_q;
        mem_D          = d_q;
        if (clr_go) begin
            mem_A0    = cnt[AW-1:0];
            mem_CADDR = cnt[AW-1:0];
            mem_D     = '0;
        end else if (fill_go) begin
            mem_A0    = req.fill_addr;
            mem_CADDR = req.fill_addr;
            mem_D     = req.fill_data;
        end else if (rd_go) begin
            mem_A0    = req.rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= (CLEAR_EN != 0) ? CLEAR : SERVE;
            cnt           <= '0;
            last_rd       <= 1'b1;
            acc_rd        <= 1'b0;
            a0_q          <= '0;
            caddr_q       <= '0;
            d_q           <= '0;
            mem_CEN       <= 1'b1;
            mem_WEN       <= 1'b1;
            req.rsp_valid <= 1'b0;
            req.rsp_data  <= '0;
            init_done     <= (CLEAR_EN == 0);
        end else begin
            a0_q          <= mem_A0;
            caddr_q       <= mem_CADDR;
            d_q           <= mem_D;
            mem_CEN       <= !(wr_go || rd_go);
            mem_WEN       <= !wr_go;
            // Q is valid by the end of the access cycle (negedge core).
            acc_rd        <= rd_go;
            req.rsp_valid <= acc_rd;
            if (acc_rd)
                req.rsp_data <= mem_Q;
            if (fill_go)
                last_rd <= 1'b0;
            else if (rd_go)
                last_rd <= 1'b1;
            if (clr_go) begin
                if (cnt == LAST) begin
                    state     <= SERVE;
                    init_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
